icache_fetch_arbiter: RTL and testbench
=======================================

// Module: icache_fetch_arbiter
// PURPOSE
//  Shares the single I-Cache fetch port between the way0 and way1 IFUs.
//  Round-robin grant, one transaction outstanding, 1-cycle arbitration latency.
//  On a jump flush, the in-flight fetch is drained and its response is discarded.
//  Sits between the IFUs' request_o/instAddr_fetch_o/dataOk_i/inst_fetch_i ports and the I-Cache.
// PARAMETERS
//  ADDR_WIDTH      32   fetch address width
//  INST_WIDTH      32   instruction word width
//  TIMEOUT_CYCLES  256  watchdog limit in cycles (used only with FETCH_ARB_TIMEOUT_EN)
// PORTS
//  clk               in   1           clock; all state updates on rising edge
//  reset_n           in   1           synchronous, active-low reset
//  flush_i           in   1           jump flush (core jumpFlag)
//  way0_request_i    in   1           way0 fetch request; level, held until way0_dataOk_o
//  way0_addr_i       in   ADDR_WIDTH  way0 fetch address; stable while request high
//  way0_dataOk_o     out  1           1-cycle pulse: way0 instruction valid
//  way0_inst_o       out  INST_WIDTH  instruction returned to way0
//  way1_request_i    in   1           way1 fetch request (same rules as way0)
//  way1_addr_i       in   ADDR_WIDTH  way1 fetch address
//  way1_dataOk_o     out  1           1-cycle pulse: way1 instruction valid
//  way1_inst_o       out  INST_WIDTH  instruction returned to way1
//  icache_request_o  out  1           I-Cache request; held high until icache_dataOk_i
//  icache_addr_o     out  ADDR_WIDTH  latched address of the granted request
//  icache_dataOk_i   in   1           I-Cache response pulse
//  icache_inst_i     in   INST_WIDTH  I-Cache instruction; valid with icache_dataOk_i
//  busy_o            out  1           high in any state other than IDLE
//  timeout_o         out  1           1-cycle watchdog pulse
// BEHAVIOUR
//  Reset (reset_n=0 at a clock edge): state=IDLE; icache_request_o=0; icache_addr_o=0;
//   lastGrant=1, so way0 wins the first tie; watchdog count=0; busy_o=0; timeout_o=0.
//  States: IDLE, BUSY0, BUSY1, DRAIN. icache_request_o and icache_addr_o are registered.
//  IDLE:
//   - flush_i=1: stay in IDLE. Requests seen in this cycle are ignored.
//   - Only one way requesting: grant that way.
//   - Both ways requesting: grant the way that is not lastGrant.
//   - On grant: next state BUSYn, icache_request_o<=1, icache_addr_o<=wayN_addr_i,
//     lastGrant<=n.
//  BUSYn:
//   - icache_dataOk_i=1 and flush_i=0: wayN_dataOk_o=1 (combinational), then IDLE
//     with icache_request_o<=0.
//   - icache_dataOk_i=1 and flush_i=1: response discarded (no dataOk_o), then IDLE.
//   - flush_i=1 with no dataOk: go to DRAIN; icache_request_o stays high.
//  DRAIN: wait for icache_dataOk_i. Discard the response, then IDLE.
//   flush_i in DRAIN has no further effect.
//  wayN_inst_o = icache_inst_i (combinational pass-through). Only dataOk_o qualifies it.
//   The non-granted way's dataOk_o is always 0.
//  Minimum one IDLE cycle between transactions. Peak rate: one fetch per 3 cycles.
//  A request that drops before it is granted is not an error; it is simply not granted.
//  busy_o = (state != IDLE).
// CONFIGURATION
//  FETCH_ARB_TIMEOUT_EN defined:
//   - Counter of width $clog2(TIMEOUT_CYCLES+1) increments each cycle in BUSY*/DRAIN.
//   - It clears on entering IDLE.
//   - When it reaches TIMEOUT_CYCLES with no icache_dataOk_i: timeout_o=1 for one cycle,
//     no dataOk_o is issued, and the next state is IDLE with icache_request_o<=0.
//   - icache_dataOk_i arriving in the same cycle as expiry wins: normal completion,
//     no timeout.
//  Undefined: no counter; timeout_o is tied to 0; BUSY/DRAIN wait indefinitely.
// TESTING
//  1 Reset, then way0_request_i=1, addr=0x8000_0000 -> next cycle icache_request_o=1,
//    icache_addr_o=0x8000_0000. Cache dataOk with inst=0x0000_0013 ->
//    way0_dataOk_o=1 and way0_inst_o=0x13 in the same cycle.
//  2 Both ways request continuously (addr 0x100 / 0x200), cache answers in 1 cycle ->
//    grants alternate 0,1,0,1 and icache_addr_o alternates 0x100,0x200.
//  3 BUSY1, flush_i=1 two cycles before dataOk -> DRAIN, request held high,
//    way1_dataOk_o stays 0, back in IDLE the cycle after dataOk.
//  4 flush_i and icache_dataOk_i in the same cycle in BUSY0 -> way0_dataOk_o=0, IDLE next.
//  5 reset_n=0 mid-BUSY0 -> next cycle icache_request_o=0, busy_o=0.
//    After reset, a tie is granted to way0.
//  6 FETCH_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, cache silent -> timeout_o pulses 8 cycles
//    after grant, IDLE next. Without the macro: no pulse, stays in BUSY.

Source files
------------

// File: rtl/icache_fetch_arbiter.sv
// rtl/icache_fetch_arbiter.sv - round-robin arbiter sharing one I-Cache fetch port between two IFU ways
// Optional watchdog enabled by defining FETCH_ARB_TIMEOUT_EN.
module icache_fetch_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int INST_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  flush_i,
    input  logic                  way0_request_i,
    input  logic [ADDR_WIDTH-1:0] way0_addr_i,
    output logic                  way0_dataOk_o,
    output logic [INST_WIDTH-1:0] way0_inst_o,
    input  logic                  way1_request_i,
    input  logic [ADDR_WIDTH-1:0] way1_addr_i,
    output logic                  way1_dataOk_o,
    output logic [INST_WIDTH-1:0] way1_inst_o,
    output logic                  icache_request_o,
    output logic [ADDR_WIDTH-1:0] icache_addr_o,
    input  logic                  icache_dataOk_i,
    input  logic [INST_WIDTH-1:0] icache_inst_i,
    output logic                  busy_o,
    output logic                  timeout_o
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_BUSY0 = 2'd1;
    localparam logic [1:0] S_BUSY1 = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    logic [1:0]            r_state;
    logic [1:0]            w_state_next;
    logic                  r_last;
    logic                  r_req;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  w_any_req;
    logic                  w_grant_way;
    logic                  w_timeout;
    logic                  w_deliver;

    assign w_any_req = way0_request_i | way1_request_i;
    // On a tie the way that did not win last time is served.
    assign w_grant_way = (way0_request_i && way1_request_i) ? ~r_last : way1_request_i;

`ifdef FETCH_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] r_cnt;

    // Fires in the cycle the count reaches the limit; a same-cycle response wins.
    assign w_timeout = (r_state != S_IDLE) && (r_cnt == CW'(TIMEOUT_CYCLES - 1)) && !icache_dataOk_i;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (w_state_next == S_IDLE) begin
            r_cnt <= '0;
        end else if (r_state != S_IDLE) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end
`else
    logic w_unused_timeout_cfg;
    assign w_unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
    assign w_timeout            = 1'b0;
`endif

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (!flush_i && w_any_req) begin
                    w_state_next = w_grant_way ? S_BUSY1 : S_BUSY0;
                end
            end
            S_BUSY0, S_BUSY1: begin
                if (icache_dataOk_i || w_timeout) begin
                    w_state_next = S_IDLE;
                end else if (flush_i) begin
                    w_state_next = S_DRAIN;
                end
            end
            default: begin
                if (icache_dataOk_i || w_timeout) begin
                    w_state_next = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_req   <= 1'b0;
            r_addr  <= '0;
            r_last  <= 1'b1;
        end else begin
            r_state <= w_state_next;
            r_req   <= (w_state_next != S_IDLE);
            if (r_state == S_IDLE && w_state_next != S_IDLE) begin
                r_addr <= w_grant_way ? way1_addr_i : way0_addr_i;
                r_last <= w_grant_way;
            end
        end
    end

    // A flush in the response cycle discards the instruction.
    assign w_deliver        = icache_dataOk_i && !flush_i;
    assign way0_dataOk_o    = (r_state == S_BUSY0) && w_deliver;
    assign way1_dataOk_o    = (r_state == S_BUSY1) && w_deliver;
    assign way0_inst_o      = icache_inst_i;
    assign way1_inst_o      = icache_inst_i;
    assign icache_request_o = r_req;
    assign icache_addr_o    = r_addr;
    assign busy_o           = (r_state != S_IDLE);
    assign timeout_o        = w_timeout;

endmodule

// File: tb/tb_icache_fetch_arbiter.sv
// tb/tb_icache_fetch_arbiter.sv - randomized self-checking bench for icache_fetch_arbiter
module tb_icache_fetch_arbiter;

    localparam int TO = 8;
`ifdef FETCH_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n, flush_i, r0, r1, dok;
    logic [31:0] a0, a1, inst;
    logic        way0_dataOk_o, way1_dataOk_o, icache_request_o, busy_o, timeout_o;
    logic [31:0] way0_inst_o, way1_inst_o, icache_addr_o;

    always #5 clk = ~clk;

    icache_fetch_arbiter #(.ADDR_WIDTH(32), .INST_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset_n(reset_n), .flush_i(flush_i),
        .way0_request_i(r0), .way0_addr_i(a0), .way0_dataOk_o(way0_dataOk_o), .way0_inst_o(way0_inst_o),
        .way1_request_i(r1), .way1_addr_i(a1), .way1_dataOk_o(way1_dataOk_o), .way1_inst_o(way1_inst_o),
        .icache_request_o(icache_request_o), .icache_addr_o(icache_addr_o),
        .icache_dataOk_i(dok), .icache_inst_i(inst), .busy_o(busy_o), .timeout_o(timeout_o)
    );

    int n_total = 0;
    int n_bad   = 0;

    // transaction-level reference: one outstanding fetch, owner, flushed flag, age
    bit          m_active, m_owner, m_discard, m_last;
    logic [31:0] m_addr;
    int          m_age;

    logic        o_dok0, o_dok1, o_to;
    logic [31:0] o_inst0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_active  = 1'b0;
        m_owner   = 1'b0;
        m_discard = 1'b0;
        m_last    = 1'b1;
        m_addr    = '0;
        m_age     = 0;
    endtask

    task automatic cyc();
        bit e_to, e_del, w;
        #4;
        e_to  = TO_EN && m_active && (m_age == TO - 1) && !dok;
        e_del = m_active && !m_discard && dok && !flush_i;
        check("busy", busy_o, m_active);
        check("req", icache_request_o, m_active);
        check("addr", icache_addr_o, m_addr);
        check("dok0", way0_dataOk_o, e_del && !m_owner);
        check("dok1", way1_dataOk_o, e_del && m_owner);
        check("timeout", timeout_o, e_to);
        check("inst0", way0_inst_o, inst);
        check("inst1", way1_inst_o, inst);
        o_dok0  = way0_dataOk_o;
        o_dok1  = way1_dataOk_o;
        o_to    = timeout_o;
        o_inst0 = way0_inst_o;
        @(posedge clk);
        if (!reset_n) begin
            model_reset();
        end else if (m_active) begin
            if (dok || e_to) begin
                m_active = 1'b0;
            end else begin
                if (flush_i) m_discard = 1'b1;
                m_age++;
            end
        end else if (!flush_i && (r0 || r1)) begin
            w         = (r0 && r1) ? !m_last : r1;
            m_active  = 1'b1;
            m_owner   = w;
            m_addr    = w ? a1 : a0;
            m_last    = w;
            m_age     = 0;
            m_discard = 1'b0;
        end
        #1;
    endtask

    initial begin
        int k, n_to;
        reset_n = 1'b0; flush_i = 1'b0; r0 = 1'b0; r1 = 1'b0;
        a0 = '0; a1 = '0; dok = 1'b0; inst = '0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        cyc();
        reset_n = 1'b1;

        // single request from way0, response with a nop
        r0 = 1'b1; a0 = 32'h8000_0000;
        cyc();
        check("t1_req", icache_request_o, 1);
        check("t1_addr", icache_addr_o, 32'h8000_0000);
        dok = 1'b1; inst = 32'h0000_0013;
        cyc();
        check("t1_dok0", o_dok0, 1);
        check("t1_inst0", o_inst0, 32'h13);
        r0 = 1'b0; dok = 1'b0;
        cyc();

        // flush coinciding with the response
        r0 = 1'b1; a0 = 32'h40;
        cyc();
        flush_i = 1'b1; dok = 1'b1;
        cyc();
        check("t4_dok0", o_dok0, 0);
        check("t4_idle", busy_o, 0);
        r0 = 1'b0; flush_i = 1'b0; dok = 1'b0;

        // flush two cycles ahead of the response drains it
        r1 = 1'b1; a1 = 32'h300;
        cyc();
        flush_i = 1'b1;
        cyc();
        r1 = 1'b0; flush_i = 1'b0;
        cyc();
        check("t3_req_held", icache_request_o, 1);
        check("t3_busy", busy_o, 1);
        dok = 1'b1;
        cyc();
        check("t3_dok1", o_dok1, 0);
        check("t3_idle", busy_o, 0);
        dok = 1'b0;

        // reset mid-transaction, then alternating ties
        r0 = 1'b1; a0 = 32'h100; a1 = 32'h200;
        cyc();
        reset_n = 1'b0;
        cyc();
        check("t5_req", icache_request_o, 0);
        check("t5_busy", busy_o, 0);
        reset_n = 1'b1; r1 = 1'b1;
        k = 0;
        for (int i = 0; i < 12; i++) begin
            dok = m_active && (m_age == 1);
            cyc();
            if (m_active && m_age == 0) begin
                check("t2_seq", icache_addr_o, k[0] ? 32'h200 : 32'h100);
                k++;
            end
        end
        check("t2_grants", k, 4);
        r0 = 1'b0; r1 = 1'b0; dok = 1'b1;
        repeat (2) cyc();
        dok = 1'b0;

        // silent cache: watchdog pulse only when enabled
        r1 = 1'b1; a1 = 32'h500; n_to = 0;
        for (int i = 0; i < 12; i++) begin
            cyc();
            if (o_to) n_to++;
        end
        check("t6_pulses", n_to, TO_EN ? 1 : 0);
        check("t6_busy", busy_o, 1);
        r1 = 1'b0; dok = 1'b1;
        cyc();
        dok = 1'b0;
        cyc();

        for (int i = 0; i < 3000; i++) begin
            if (r0 && (o_dok0 || (flush_i && $urandom % 2 == 0) ||
                       (!(m_active && !m_owner) && $urandom % 16 == 0))) r0 = 1'b0;
            else if (!r0 && $urandom % 2 == 0) begin r0 = 1'b1; a0 = $urandom; end
            if (r1 && (o_dok1 || (flush_i && $urandom % 2 == 0) ||
                       (!(m_active && m_owner) && $urandom % 16 == 0))) r1 = 1'b0;
            else if (!r1 && $urandom % 2 == 0) begin r1 = 1'b1; a1 = $urandom; end
            flush_i = ($urandom % 8 == 0);
            dok     = m_active ? ($urandom % 3 == 0) : ($urandom % 16 == 0);
            inst    = $urandom;
            cyc();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
